neuron_lut_writer: RTL and testbench

// - Runtime loader and lookup for one LogicNets neuron truth table: the write side of the fixed LUT-neuron ROM.
// - Accepts a packed truth-table stream, writes it into distributed RAM, then serves registered lookups.
// - Sits between the configuration stream and a layer-0 neuron slot, so tables are replaced without re-synthesis.

---
 rtl/neuron_lut_writer.sv | 124 ++++++++++++
 tb/tb_neuron_lut_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_lut_writer.sv
// neuron_lut_writer: streams a packed LogicNets truth table into distributed RAM, then serves 1-cycle registered lookups.
// Optional build macro LUT_WRITER_CHECKSUM_EN adds a running beat checksum (csum) verified against exp_csum at the final beat.
module neuron_lut_writer #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 2,
   parameter int WORD_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [WORD_W-1:0]   s_data,
   input  logic                s_last,
`ifdef LUT_WRITER_CHECKSUM_EN
   input  logic [15:0]         exp_csum,
   output logic [15:0]         csum,
`endif
   input  logic [IN_BITS-1:0]  lookup_addr,
   output logic [OUT_BITS-1:0] lookup_data,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int EPB   = WORD_W / OUT_BITS;
   localparam int DEPTH = 2 ** IN_BITS;
   localparam logic [IN_BITS-1:0] LP_EPB  = IN_BITS'(EPB);
   localparam logic [IN_BITS-1:0] LP_LAST = IN_BITS'(DEPTH - EPB);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [IN_BITS-1:0]  r_addr;
   logic [OUT_BITS-1:0] r_mem [DEPTH];
   logic [OUT_BITS-1:0] r_lookup;
   logic                w_accept;
   logic                w_final;
   logic                w_csum_ok;

   // A start in LOAD restarts the load, so its coincident beat is dropped.
   assign w_accept = (r_state == ST_LOAD) && s_valid && !start;
   assign w_final  = (r_addr == LP_LAST);

`ifdef LUT_WRITER_CHECKSUM_EN
   logic [15:0] r_csum;
   logic [15:0] w_csum_nxt;

   assign w_csum_nxt = r_csum + 16'(s_data);
   assign w_csum_ok  = (w_csum_nxt == exp_csum);
   assign csum       = r_csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_csum <= '0;
      else if (start)
         r_csum <= '0;
      else if (w_accept)
         r_csum <= w_csum_nxt;
   end
`else
   assign w_csum_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start)
               w_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (start)
               w_next = ST_LOAD;
            else if (w_accept) begin
               if (w_final != s_last)
                  w_next = ST_ERR;
               else if (w_final)
                  w_next = w_csum_ok ? ST_DONE : ST_ERR;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_addr <= '0;
      else if (start)
         r_addr <= '0;
      else if (w_accept)
         r_addr <= r_addr + LP_EPB;
   end

   // Table storage is deliberately unreset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int j = 0; j < EPB; j++)
            r_mem[r_addr + IN_BITS'(j)] <= s_data[j*OUT_BITS +: OUT_BITS];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_lookup <= '0;
      else
         r_lookup <= (r_state == ST_DONE) ? r_mem[lookup_addr] : '0;
   end

   assign lookup_data = r_lookup;
   assign s_ready     = (r_state == ST_LOAD);
   assign busy        = (r_state == ST_LOAD);
   assign done        = (r_state == ST_DONE);
   assign err         = (r_state == ST_ERR);

endmodule

// File: tb/tb_neuron_lut_writer.sv
// Bench for neuron_lut_writer: loads tables through the stream port and scoreboards lookups against a bench-side table model.
`timescale 1ns/1ps
module tb_neuron_lut_writer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       s_last;
   logic [7:0] lookup_addr;
   logic [1:0] lookup_data;
   logic       busy;
   logic       done;
   logic       err;
`ifdef LUT_WRITER_CHECKSUM_EN
   logic [15:0] exp_csum;
   logic [15:0] csum;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] img [64];
   logic [1:0] ref_tab [256];
   bit         tab_valid;
   logic [1:0] sb_q [$];

   always #5 clk = ~clk;

   neuron_lut_writer #(.IN_BITS(8), .OUT_BITS(2), .WORD_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
`ifdef LUT_WRITER_CHECKSUM_EN
      .exp_csum    (exp_csum),
      .csum        (csum),
`endif
      .lookup_addr (lookup_addr),
      .lookup_data (lookup_data),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      tab_valid = 1'b0;
   endtask

   task automatic send_beat(input int b, input bit last);
      s_valid = 1'b1;
      s_data  = img[b];
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic build_model();
      for (int a = 0; a < 256; a++)
         ref_tab[a] = img[a >> 2][(a & 3) * 2 +: 2];
      tab_valid = 1'b1;
   endtask

   // last_beat < 0 means no s_last is ever sent; csum_adj perturbs exp_csum.
   task automatic load(input int last_beat, input bit gaps, input logic [15:0] csum_adj);
      bit          good;
      logic [15:0] sum;
      sum = '0;
      for (int i = 0; i < 64; i++)
         sum = sum + {8'h00, img[i]};
`ifdef LUT_WRITER_CHECKSUM_EN
      exp_csum = sum + csum_adj;
`endif
      pulse_start();
      check("ready_after_start", {15'd0, s_ready}, 16'd1);
      check("busy_after_start", {15'd0, busy}, 16'd1);
      for (int b = 0; b < 64; b++) begin
         if (gaps)
            for (int g = 0; g < 4 && $urandom_range(99) < 30; g++)
               tick();
         if (b == 32)
            check("lookup_in_load", {14'd0, lookup_data}, 16'd0);
         send_beat(b, b == last_beat);
         if (b == last_beat)
            break;
      end
      good = (last_beat == 63) && (csum_adj == 16'd0);
      check("done", {15'd0, done}, {15'd0, good});
      check("err", {15'd0, err}, {15'd0, !good});
      check("busy_end", {15'd0, busy}, 16'd0);
      check("ready_end", {15'd0, s_ready}, 16'd0);
`ifdef LUT_WRITER_CHECKSUM_EN
      if (last_beat == 63)
         check("csum", csum, sum);
`endif
      if (good)
         build_model();
   endtask

   task automatic lookup(input logic [7:0] a);
      logic [1:0] exp;
      lookup_addr = a;
      sb_q.push_back(tab_valid ? ref_tab[a] : 2'b00);
      tick();
      exp = sb_q.pop_front();
      check($sformatf("lookup_%0d", a), {14'd0, lookup_data}, {14'd0, exp});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      lookup_addr = '0; tab_valid = 1'b0;
`ifdef LUT_WRITER_CHECKSUM_EN
      exp_csum = '0;
`endif
      repeat (2) tick();
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_done", {15'd0, done}, 16'd0);
      check("rst_err", {15'd0, err}, 16'd0);
      check("rst_ready", {15'd0, s_ready}, 16'd0);
      check("rst_lookup", {14'd0, lookup_data}, 16'd0);
      rst_n = 1'b1;
      tick();
      check("idle_ready", {15'd0, s_ready}, 16'd0);
      lookup(8'd3);

      // Ramp pattern: every beat holds entries 0,1,2,3.
      foreach (img[i]) img[i] = 8'hE4;
      load(63, 1'b0, 16'd0);
      for (int a = 0; a < 4; a++) lookup(8'(a));
      lookup(8'd255);

      // Single non-zero entry at 51 (beat 12, slot 3).
      foreach (img[i]) img[i] = 8'h00;
      img[12] = 8'h40;
      load(63, 1'b0, 16'd0);
      lookup(8'd51);
      lookup(8'd50);
      lookup(8'd52);

      // Early s_last, then recovery with a good load.
      foreach (img[i]) img[i] = 8'($urandom);
      load(10, 1'b0, 16'd0);
      lookup(8'h00);
      load(63, 1'b0, 16'd0);
      for (int k = 0; k < 6; k++) lookup(8'($urandom));

      // Missing s_last, back-to-back and with idle gaps.
      load(-1, 1'b0, 16'd0);
      lookup(8'd7);
      load(-1, 1'b1, 16'd0);
      lookup(8'd9);

      // Reset in the middle of a load.
      pulse_start();
      for (int b = 0; b < 20; b++) send_beat(b, 1'b0);
      s_valid = 1'b1;
      s_data  = img[20];
      rst_n   = 1'b0;
      #1;
      check("arst_busy", {15'd0, busy}, 16'd0);
      check("arst_done", {15'd0, done}, 16'd0);
      check("arst_err", {15'd0, err}, 16'd0);
      check("arst_ready", {15'd0, s_ready}, 16'd0);
      check("arst_lookup", {14'd0, lookup_data}, 16'd0);
      s_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      lookup(8'd5);
      foreach (img[i]) img[i] = 8'($urandom);
      load(63, 1'b1, 16'd0);
      for (int k = 0; k < 6; k++) lookup(8'($urandom));

      // Restart mid-load: the partial data must be replaced by the full load.
      foreach (img[i]) img[i] = 8'h1B;
      pulse_start();
      for (int b = 0; b < 5; b++) send_beat(b, 1'b0);
      foreach (img[i]) img[i] = 8'($urandom);
      load(63, 1'b0, 16'd0);
      for (int k = 0; k < 4; k++) lookup(8'(k));
      lookup(8'd128);

`ifdef LUT_WRITER_CHECKSUM_EN
      foreach (img[i]) img[i] = 8'hFF;
      load(63, 1'b0, 16'd0);
      check("csum_ff", csum, 16'h3FC0);
      lookup(8'd77);
      load(63, 1'b0, 16'd1);
      lookup(8'd77);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
